point_fetch_scheduler: RTL and testbench

POINT_FETCH_SCHEDULER -- requirements
Module: point_fetch_scheduler

---
 rtl/point_fetch_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_point_fetch_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/point_fetch_scheduler.sv
// Point-memory read scheduler. It sweeps a point cloud in M-point feeder blocks and interleaves
// CORE_NUMBER-point core refill bursts. Define FETCH_STATS_EN to add block/burst counters.
module point_fetch_scheduler #(
  parameter int N           = 16,
  parameter int M           = 8,
  parameter int CORE_NUMBER = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [N-1:0]     point_cloud_size,
  input  logic             core_req,
  input  logic [N-1:0]     core_base,
  output logic             core_ack,
  output logic             mem_rd_en,
  output logic [N-1:0]     mem_rd_addr,
  output logic             mem_rd_sel,
  output logic [N-1:0]     feeder_pos,
  output logic [M-1:0]     feeder_lane_vld,
  output logic             feeder_block_done,
  output logic             feeder_wrap,
  output logic             busy
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]      feeder_block_cnt,
  output logic [31:0]      core_burst_cnt
`endif
);

  localparam int LW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (CORE_NUMBER > 1) ? $clog2(CORE_NUMBER) : 1;

  typedef enum logic [1:0] {IDLE, FEED, CORE, STOPPING} state_t;

  state_t        state;
  logic [N-1:0]  size_q;
  logic [LW-1:0] lane;
  logic [CW-1:0] beat;

  // Address of feeder lane k; lanes at or past the cloud size read address 0.
  function automatic logic [N-1:0] lane_addr(input logic [N-1:0] base,
                                             input logic [N-1:0] size,
                                             input logic [N:0]   k);
    logic [N:0] sum;
    sum = {1'b0, base} + k;
    return (sum < {1'b0, size}) ? sum[N-1:0] : '0;
  endfunction

  function automatic logic [M-1:0] lane_mask(input logic [N-1:0] base,
                                             input logic [N-1:0] size);
    logic [M-1:0] mask;
    logic [N:0]   sum;
    mask = '0;
    for (int k = 0; k < M; k++) begin
      sum     = {1'b0, base} + (N+1)'(k);
      mask[k] = (sum < {1'b0, size});
    end
    return mask;
  endfunction

  logic [N:0]   pos_plus_m;
  logic         block_wraps;
  logic [N-1:0] next_pos;
  logic [N:0]   next_lane;
  logic [N:0]   base_wide;
  logic [N:0]   base_reduced;
  logic [N-1:0] core_first;
  logic [N:0]   core_inc;
  logic [N-1:0] core_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pos_plus_m   = {1'b0, feeder_pos} + (N+1)'(M);
    block_wraps  = (pos_plus_m >= {1'b0, size_q});
    next_pos     = block_wraps ? '0 : pos_plus_m[N-1:0];
    next_lane    = (N+1)'(lane) + (N+1)'(1);
    // A core base is assumed to lie below twice the cloud size, so one subtraction reduces it.
    base_wide    = {1'b0, core_base};
    base_reduced = base_wide - {1'b0, size_q};
    core_first   = (base_wide >= {1'b0, size_q}) ? base_reduced[N-1:0] : core_base;
    core_inc     = {1'b0, mem_rd_addr} + (N+1)'(1);
    core_next    = (core_inc >= {1'b0, size_q}) ? '0 : core_inc[N-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the values from before the edge regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= IDLE;
      size_q            <= '0;
      lane              <= '0;
      beat              <= '0;
      mem_rd_en         <= 1'b0;
      mem_rd_addr       <= '0;
      mem_rd_sel        <= 1'b0;
      feeder_pos        <= '0;
      feeder_lane_vld   <= '0;
      core_ack          <= 1'b0;
      feeder_block_done <= 1'b0;
      feeder_wrap       <= 1'b0;
      busy              <= 1'b0;
    end else begin
      // Pulses and the read strobe are asserted only by the branches that need them.
      core_ack          <= 1'b0;
      feeder_block_done <= 1'b0;
      feeder_wrap       <= 1'b0;
      mem_rd_en         <= 1'b0;
      mem_rd_sel        <= 1'b0;
      mem_rd_addr       <= '0;

      case (state)
        IDLE: begin
          if (start) begin
            size_q          <= point_cloud_size;
            feeder_pos      <= '0;
            feeder_lane_vld <= lane_mask('0, point_cloud_size);
            lane            <= '0;
            busy            <= 1'b1;
            if (point_cloud_size == '0) begin
              state <= STOPPING;
            end else begin
              state     <= FEED;
              mem_rd_en <= 1'b1;
            end
          end
        end

        FEED: begin
          if (lane != LW'(M - 1)) begin
            lane        <= lane + 1'b1;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= lane_addr(feeder_pos, size_q, next_lane);
          end else begin
            // Block boundary: report the block, advance the sweep, then arbitrate.
            lane              <= '0;
            feeder_block_done <= 1'b1;
            feeder_wrap       <= block_wraps;
            feeder_pos        <= next_pos;
            feeder_lane_vld   <= lane_mask(next_pos, size_q);
            if (stop) begin
              state <= STOPPING;
            end else if (core_req) begin
              state       <= CORE;
              beat        <= '0;
              mem_rd_en   <= 1'b1;
              mem_rd_sel  <= 1'b1;
              mem_rd_addr <= core_first;
            end else begin
              state       <= FEED;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= next_pos;
            end
          end
        end

        CORE: begin
          if (beat != CW'(CORE_NUMBER - 1)) begin
            beat        <= beat + 1'b1;
            mem_rd_en   <= 1'b1;
            mem_rd_sel  <= 1'b1;
            mem_rd_addr <= core_next;
          end else begin
            // After a core burst one feeder block always runs before the next grant.
            core_ack <= 1'b1;
            if (stop) begin
              state <= STOPPING;
            end else begin
              state       <= FEED;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= feeder_pos;
            end
          end
        end

        STOPPING: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      feeder_block_cnt <= '0;
      core_burst_cnt   <= '0;
    end else if (state == IDLE && start) begin
      feeder_block_cnt <= '0;
      core_burst_cnt   <= '0;
    end else begin
      if (feeder_block_done && feeder_block_cnt != '1) feeder_block_cnt <= feeder_block_cnt + 1'b1;
      if (core_ack && core_burst_cnt != '1)            core_burst_cnt   <= core_burst_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_point_fetch_scheduler.sv
// Directed bench for point_fetch_scheduler: a burst-queue model is compared every cycle,
// plus literal expectations at hand-computed cycles of each scenario.
module tb_point_fetch_scheduler;

  localparam int N  = 16;
  localparam int M  = 8;
  localparam int CN = 2;

  logic          clock;
  logic          reset;
  logic          start;
  logic          stop;
  logic [N-1:0]  point_cloud_size;
  logic          core_req;
  logic [N-1:0]  core_base;
  logic          core_ack;
  logic          mem_rd_en;
  logic [N-1:0]  mem_rd_addr;
  logic          mem_rd_sel;
  logic [N-1:0]  feeder_pos;
  logic [M-1:0]  feeder_lane_vld;
  logic          feeder_block_done;
  logic          feeder_wrap;
  logic          busy;
`ifdef FETCH_STATS_EN
  logic [31:0]   feeder_block_cnt;
  logic [31:0]   core_burst_cnt;
`endif

  point_fetch_scheduler #(.N(N), .M(M), .CORE_NUMBER(CN)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .stop              (stop),
    .point_cloud_size  (point_cloud_size),
    .core_req          (core_req),
    .core_base         (core_base),
    .core_ack          (core_ack),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_sel        (mem_rd_sel),
    .feeder_pos        (feeder_pos),
    .feeder_lane_vld   (feeder_lane_vld),
    .feeder_block_done (feeder_block_done),
    .feeder_wrap       (feeder_wrap),
    .busy              (busy)
`ifdef FETCH_STATS_EN
    ,
    .feeder_block_cnt  (feeder_block_cnt),
    .core_burst_cnt    (core_burst_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each burst is expanded into a queue of reads; an empty queue marks a boundary.
  typedef struct {
    int unsigned addr;
    bit          sel;
  } rd_t;

  rd_t         q[$];
  int          mode;       // 0 idle, 1 running, 2 stopping
  bit          last_core;
  int unsigned lat_size;
  int unsigned pos;
  logic          e_busy, e_rd, e_sel, e_ack, e_done, e_wrap;
  logic [N-1:0]  e_addr, e_pos;
  logic [M-1:0]  e_mask;
  logic [31:0]   e_fcnt, e_ccnt;

  function automatic logic [M-1:0] mask_of(input int unsigned p, input int unsigned sz);
    logic [M-1:0] m;
    m = '0;
    for (int k = 0; k < M; k++) m[k] = (p + k < sz);
    return m;
  endfunction

  task automatic push_feed();
    for (int k = 0; k < M; k++) q.push_back('{(pos + k < lat_size) ? pos + k : 0, 1'b0});
  endtask

  task automatic push_core(input int unsigned base);
    for (int i = 0; i < CN; i++) q.push_back('{(base + i) % lat_size, 1'b1});
  endtask

  always @(posedge clock) begin
    rd_t r;
    if (!reset) begin
      mode = 0; q.delete(); last_core = 0; lat_size = 0; pos = 0;
      e_busy = 0; e_rd = 0; e_sel = 0; e_ack = 0; e_done = 0; e_wrap = 0;
      e_addr = '0; e_pos = '0; e_mask = '0; e_fcnt = '0; e_ccnt = '0;
    end else begin
      if (mode == 0 && start) begin
        e_fcnt = '0; e_ccnt = '0;
      end else begin
        if (e_done && e_fcnt != '1) e_fcnt = e_fcnt + 1;
        if (e_ack && e_ccnt != '1)  e_ccnt = e_ccnt + 1;
      end
      e_done = 0; e_wrap = 0; e_ack = 0;
      case (mode)
        0: if (start) begin
          lat_size  = point_cloud_size;
          pos       = 0;
          e_mask    = mask_of(0, lat_size);
          last_core = 0;
          if (lat_size == 0) mode = 2;
          else begin mode = 1; push_feed(); end
        end
        2: mode = 0;
        default: begin
          r = q.pop_front();
          if (q.size() == 0) begin
            if (!r.sel) begin
              e_done = 1;
              if (pos + M >= lat_size) begin pos = 0; e_wrap = 1; end
              else pos = pos + M;
              e_mask    = mask_of(pos, lat_size);
              last_core = 0;
            end else begin
              e_ack     = 1;
              last_core = 1;
            end
            if (stop) mode = 2;
            else if (!last_core && core_req) push_core(core_base);
            else push_feed();
          end
        end
      endcase
      e_rd   = (mode == 1);
      e_addr = (mode == 1) ? N'(q[0].addr) : '0;
      e_sel  = (mode == 1) ? q[0].sel : 1'b0;
      e_busy = (mode != 0);
      e_pos  = N'(pos);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cycle_outputs",
            64'({busy, mem_rd_en, mem_rd_sel, core_ack, feeder_block_done, feeder_wrap,
                 mem_rd_addr, feeder_pos, feeder_lane_vld}),
            64'({e_busy, e_rd, e_sel, e_ack, e_done, e_wrap, e_addr, e_pos, e_mask}));
`ifdef FETCH_STATS_EN
      check("cycle_counters", {feeder_block_cnt, core_burst_cnt}, {e_fcnt, e_ccnt});
`endif
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) step();
    check("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic pulse_start(input int unsigned size);
    point_cloud_size = N'(size);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; core_req = 1'b0;
    core_base = '0; point_cloud_size = '0;
    step(2);
    reset  = 1'b1;
    chk_en = 1'b1;
    check("reset_state",
          64'({busy, mem_rd_en, mem_rd_sel, core_ack, feeder_block_done, feeder_wrap,
               mem_rd_addr, feeder_pos, feeder_lane_vld}), 64'(0));

    // Sweep of 20 points with no core traffic; a second start mid-block is ignored.
    pulse_start(20);
    check("s1_pos_c0", 64'(feeder_pos), 64'(0));
    check("s1_mask_c0", 64'(feeder_lane_vld), 64'hFF);
    step(3);
    start = 1'b1; point_cloud_size = N'(4);
    step();
    start = 1'b0;
    step(4);
    check("s1_pos_c8", 64'({feeder_pos, feeder_block_done}), 64'({16'd8, 1'b1}));
    step(8);
    check("s1_pos_c16", 64'({feeder_pos, feeder_lane_vld, mem_rd_addr}), 64'({16'd16, 8'h0F, 16'd16}));
    step(4);
    check("s1_pad_lane", 64'({mem_rd_en, mem_rd_addr}), 64'({1'b1, 16'd0}));
    step(4);
    check("s1_wrap", 64'({feeder_pos, feeder_wrap, feeder_block_done}), 64'({16'd0, 1'b1, 1'b1}));
    stop = 1'b1;
    wait_idle();
    stop = 1'b0;

    // Core requests held high alternate with feeder blocks; stop wins over core_req.
    core_req = 1'b1; core_base = N'(5);
    pulse_start(20);
    step(8);
    check("s2_core_rd5", 64'({mem_rd_sel, mem_rd_addr, feeder_block_done}), 64'({1'b1, 16'd5, 1'b1}));
    step();
    check("s2_core_rd6", 64'({mem_rd_sel, mem_rd_addr, core_ack}), 64'({1'b1, 16'd6, 1'b0}));
    step();
    check("s2_core_ack", 64'({core_ack, mem_rd_sel, mem_rd_addr}), 64'({1'b1, 1'b0, 16'd8}));
    step();
    stop = 1'b1;
    step(7);
    check("s2_stop_no_core", 64'({mem_rd_en, feeder_block_done, busy}), 64'({1'b0, 1'b1, 1'b1}));
    step();
    check("s2_busy_fall", 64'(busy), 64'(0));
    stop = 1'b0; core_req = 1'b0;

    // Request raised mid-block waits for the block; core addresses wrap past the size.
    core_base = N'(19);
    pulse_start(20);
    step(3);
    core_req = 1'b1;
    step(4);
    check("s3_block_end", 64'({mem_rd_en, mem_rd_sel, mem_rd_addr}), 64'({1'b1, 1'b0, 16'd7}));
    step();
    check("s3_core_19", 64'({mem_rd_sel, mem_rd_addr}), 64'({1'b1, 16'd19}));
    step();
    check("s3_core_wrap0", 64'({mem_rd_en, mem_rd_sel, mem_rd_addr}), 64'({1'b1, 1'b1, 16'd0}));
    step();
    core_req = 1'b0; stop = 1'b1;
    wait_idle();
    stop = 1'b0;

    // Reset in the middle of a core burst leaves no acknowledge behind.
    core_req = 1'b1; core_base = N'(5);
    pulse_start(20);
    step(8);
    check("s4_in_core", 64'({mem_rd_sel, mem_rd_addr}), 64'({1'b1, 16'd5}));
    reset = 1'b0;
    step();
    check("s4_reset_outputs",
          64'({busy, mem_rd_en, mem_rd_sel, core_ack, feeder_block_done, feeder_wrap,
               mem_rd_addr, feeder_pos, feeder_lane_vld}), 64'(0));
`ifdef FETCH_STATS_EN
    check("s4_reset_counters", {feeder_block_cnt, core_burst_cnt}, 64'(0));
`endif
    reset = 1'b1; core_req = 1'b0;
    step();
    check("s4_no_ack", 64'({core_ack, busy}), 64'(0));

    // Zero-size cloud: one stopping cycle, no reads.
    pulse_start(0);
    check("s5_zero_size", 64'({busy, mem_rd_en}), 64'({1'b1, 1'b0}));
    step();
    check("s5_zero_idle", 64'(busy), 64'(0));
    step(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
